semaforo_param: RTL
===================

Name: semaforo_param

Overview:
- Parametrised successor of the two-road factored traffic-light controller.
- Supports N_DIR directions with round-robin service, cycle-count timed phases and a minimum/maximum green time.
- Adds an all-red clearance phase and a parade mode that holds a chosen direction green.
- Sits at the top of the traffic-light design and drives one 3-bit lamp group per direction.

Parameters:
- N_DIR, 2, number of directions (>=2).
- GREEN_MIN, 4, minimum green duration in cycles (>=1).
- GREEN_MAX, 12, green duration after which a busy direction yields to waiting traffic (>=GREEN_MIN).
- YELLOW_T, 2, yellow duration in cycles (>=1).
- ALLRED_T, 1, all-red clearance in cycles (0 = phase skipped).
- PARADE_DIR, 1, direction held green in parade mode (<N_DIR).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- T  input  N_DIR  traffic sensors; T[i]=1 means vehicles waiting or flowing on direction i.
- P  input  1  parade request; sets parade mode.
- R  input  1  parade release; clears parade mode.
- L  output  3*N_DIR  lamps; L[3i+2:3i] is {red,yellow,green} for direction i (one-hot).
- act_dir  output  clog2(N_DIR)  index of the direction currently being served.
- parade  output  1  registered parade-mode flag.

Behaviour:
- Registers:
  - phase in {GREEN, YELLOW, ALLRED}.
  - act_dir.
  - timer, width clog2(GREEN_MAX+1), cleared on every phase entry, increments each cycle, saturates at GREEN_MAX.
  - parade.
- Reset (reset=0, immediate, asynchronous): phase=GREEN, act_dir=0, timer=0, parade=0. Hence L = direction 0 green (3'b001), all others red (3'b100).
- Lamps are Moore outputs decoded from phase/act_dir only:
  - act_dir shows 001 in GREEN, 010 in YELLOW, 100 in ALLRED.
  - Non-active directions always show 100.
  - At most one direction is non-red in any cycle.
- Parade flag update each edge: R=1 clears it (R has priority over P when both are 1); otherwise P=1 sets it; otherwise it holds.
- hold = parade & (act_dir==PARADE_DIR), using the registered flag.
- GREEN exit: evaluated at an edge when timer >= GREEN_MIN-1 and hold=0, and either condition holds:
  - T[act_dir]==0; or
  - timer >= GREEN_MAX-1 and some other direction has T=1.
  - When the condition is true, the next phase is YELLOW.
- GREEN timing consequences: minimum green is GREEN_MIN cycles. With T[act_dir]=1 and no other traffic, green persists indefinitely.
- YELLOW: exactly YELLOW_T cycles, then ALLRED. If ALLRED_T=0, go directly to GREEN of the next direction.
- ALLRED: exactly ALLRED_T cycles, then GREEN.
- act_dir advances to (act_dir+1) mod N_DIR on the edge entering the next GREEN. Wrap from N_DIR-1 to 0.
- No direction is skipped, even one with T=0; its green then lasts exactly GREEN_MIN cycles.
- Parade set while another direction is green or yellow: rotation continues normally. When PARADE_DIR reaches GREEN, it holds there.
- Parade cleared while holding: normal GREEN exit rules apply from the next edge. The timer is already saturated past GREEN_MIN, so exit occurs as soon as the exit condition is met.
- Parade does not affect YELLOW or ALLRED durations. An in-progress yellow always completes.
- Sensor changes during YELLOW/ALLRED are ignored.
- Reset asserted mid-phase: immediate return to the reset state. After release, the first green of direction 0 again lasts at least GREEN_MIN cycles.
- X on T/P/R while reset=0 is not required to be handled.

Test Plan:
- Reset, defaults (N_DIR=2): reset low at t=0, release at 7 ns, T=0. Required: L=6'b100_001 held for 4 cycles, then 100_010 for 2 cycles, 100_100 for 1 cycle, then 001_100 (direction 1 green), act_dir=1.
- Min/max green: T=2'b01 constant. Required: direction 0 stays green indefinitely. Then set T=2'b11 after 3 cycles. Required: direction 0 leaves green exactly at its 12th green cycle; yellow for 2 cycles, all-red for 1, then direction 1 green.
- Parade hold: P pulsed 1 cycle while direction 0 is green, T=0. Required: parade=1 next cycle; direction 1 reaches green and holds for over 50 cycles despite T=0. R pulsed: parade=0 next cycle; direction 1 enters yellow on the following edge.
- Simultaneous P=R=1 with parade=0, and again with parade=1. Required: parade=0 after the edge in both cases.
- Reset mid-yellow: assert reset during direction 1 yellow. Required: L=100_001, act_dir=0, parade=0 immediately (before the next clk edge).
- N_DIR=4, ALLRED_T=0, T=0: required green order 0,1,2,3,0 with no all-red phase, each green 4 cycles and each yellow 2 cycles. At most one non-red lamp group in every cycle (assertion).

Source files
------------

// File: rtl/semaforo_param.sv
// rtl/semaforo_param.sv - N-direction round-robin traffic-light controller with parade hold
module semaforo_param #(
    parameter int N_DIR      = 2,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 12,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1,
    parameter int PARADE_DIR = 1,
    localparam int AW        = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_DIR-1:0]   T,
    input  logic               P,
    input  logic               R,
    output logic [3*N_DIR-1:0] L,
    output logic [AW-1:0]      act_dir,
    output logic               parade
);

    // The timer must reach the longest phase length it is compared against.
    localparam int T_SAT0 = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int T_SAT  = (T_SAT0 > ALLRED_T) ? T_SAT0 : ALLRED_T;
    localparam int TW     = $clog2(T_SAT + 1);

    localparam logic [TW-1:0] SAT_V    = TW'(T_SAT);
    localparam logic [TW-1:0] GMIN_M1  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_M1  = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] YEL_M1   = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ARED_M1  = TW'((ALLRED_T > 0) ? ALLRED_T - 1 : 0);
    localparam logic [AW-1:0] LAST_DIR = AW'(N_DIR - 1);
    localparam logic [AW-1:0] PAR_DIR  = AW'(PARADE_DIR);

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } phase_t;

    phase_t        phase, phase_nxt;
    logic [AW-1:0] dir_nxt, dir_inc;
    logic [TW-1:0] timer, timer_nxt;
    logic          parade_nxt;
    logic          hold;
    logic          others;
    logic          entry;

    // State registers: phase, served direction, phase timer, parade flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase   <= GREEN;
            act_dir <= '0;
            timer   <= '0;
            parade  <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            act_dir <= dir_nxt;
            timer   <= timer_nxt;
            parade  <= parade_nxt;
        end
    end

    // Waiting traffic on any direction other than the one being served.
    always_comb begin
        others = 1'b0;
        for (int i = 0; i < N_DIR; i++) begin
            if ((AW'(i) != act_dir) && T[i]) begin
                others = 1'b1;
            end
        end
    end

    // Next phase, next direction, timer and parade flag.
    always_comb begin
        phase_nxt  = phase;
        dir_nxt    = act_dir;
        entry      = 1'b0;
        dir_inc    = (act_dir == LAST_DIR) ? '0 : act_dir + 1'b1;
        hold       = parade && (act_dir == PAR_DIR);
        parade_nxt = R ? 1'b0 : (P ? 1'b1 : parade);
        case (phase)
            GREEN: begin
                if ((timer >= GMIN_M1) && !hold &&
                    (!T[act_dir] || ((timer >= GMAX_M1) && others))) begin
                    phase_nxt = YELLOW;
                    entry     = 1'b1;
                end
            end
            YELLOW: begin
                if (timer == YEL_M1) begin
                    entry = 1'b1;
                    if (ALLRED_T == 0) begin
                        phase_nxt = GREEN;
                        dir_nxt   = dir_inc;
                    end else begin
                        phase_nxt = ALLRED;
                    end
                end
            end
            ALLRED: begin
                if (timer == ARED_M1) begin
                    phase_nxt = GREEN;
                    dir_nxt   = dir_inc;
                    entry     = 1'b1;
                end
            end
            default: begin
                phase_nxt = GREEN;
                entry     = 1'b1;
            end
        endcase
        if (entry) begin
            timer_nxt = '0;
        end else if (timer == SAT_V) begin
            timer_nxt = timer;
        end else begin
            timer_nxt = timer + 1'b1;
        end
    end

    // Moore lamp decode: only the served direction ever leaves red.
    always_comb begin
        L = '0;
        for (int i = 0; i < N_DIR; i++) begin
            if (AW'(i) == act_dir) begin
                case (phase)
                    GREEN:   L[3*i +: 3] = 3'b001;
                    YELLOW:  L[3*i +: 3] = 3'b010;
                    default: L[3*i +: 3] = 3'b100;
                endcase
            end else begin
                L[3*i +: 3] = 3'b100;
            end
        end
    end

endmodule
